// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and ram-side signals shared between mem_arbiter and its environment.
// slave: the arbiter's view; master: the requesters plus the ram/bus-driver view.
interface mem_arbiter_if #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int AWIDTH    = 12
) ();
  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds them until ackN
  // pulses for exactly one cycle (errN and rdata qualify only that pulse); in the ack cycle it
  // drops reqN or presents its next request. A req still high afterwards is a new request.
  logic                 req0;
  logic                 we0;
  logic [CPUAWIDTH-1:0] addr0;
  logic [DWIDTH-1:0]    wdata0;
  logic                 ack0;
  logic                 err0;
  logic                 req1;
  logic                 we1;
  logic [CPUAWIDTH-1:0] addr1;
  logic [DWIDTH-1:0]    wdata1;
  logic                 ack1;
  logic                 err1;
  logic [DWIDTH-1:0]    rdata;
  logic [AWIDTH-1:0]    ram_addr;
  logic                 ram_rdEn;
  logic                 ram_wrEn;
  logic [DWIDTH-1:0]    ram_wdata;
  logic [DWIDTH-1:0]    ram_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    output ack0, err0, ack1, err1, rdata, ram_addr, ram_rdEn, ram_wrEn, ram_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    input  ack0, err0, ack1, err1, rdata, ram_addr, ram_rdEn, ram_wrEn, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port ram: one access per IDLE/ACCESS/RELEASE pass,
// round-robin or fixed priority, with misaligned/out-of-range addresses rejected before the ram.
module mem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int AWIDTH    = 12,
  parameter int FAIR      = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         grant,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // First byte address past the ram: 4 * 2^AWIDTH, one bit wider so the compare never wraps.
  localparam logic [CPUAWIDTH:0] ADDR_LIMIT = {{CPUAWIDTH{1'b0}}, 1'b1} << (AWIDTH + 2);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                err_flag_q, err_flag_d;
  logic                busy_q, busy_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rdEn_q, ram_rdEn_d;
  logic                ram_wrEn_q, ram_wrEn_d;
  logic [DWIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  logic                 win;
  logic                 sel_we;
  logic [CPUAWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0]    sel_wdata;
  logic                 addr_bad;

  always_comb begin
    if (bus.req0 && bus.req1) win = (FAIR != 0) ? ~last_grant_q : 1'b0;
    else                      win = bus.req1;
    sel_we    = win ? bus.we1    : bus.we0;
    sel_addr  = win ? bus.addr1  : bus.addr0;
    sel_wdata = win ? bus.wdata1 : bus.wdata0;
    addr_bad  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_flag_d   = err_flag_q;
    busy_d       = busy_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    rdata_d      = rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_rdEn_d   = ram_rdEn_q;
    ram_wrEn_d   = ram_wrEn_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d    = ACCESS;
          grant_d    = win;
          err_flag_d = addr_bad;
          busy_d     = 1'b1;
          if (!addr_bad) begin
            ram_addr_d  = sel_addr[AWIDTH+1:2];
            ram_wdata_d = sel_wdata;
            ram_wrEn_d  = sel_we;
            ram_rdEn_d  = ~sel_we;
          end
        end
      end
      ACCESS: begin
        state_d    = RELEASE;
        ram_rdEn_d = 1'b0;
        ram_wrEn_d = 1'b0;
        // A read enable raised last cycle means the ram is now presenting the word.
        if (ram_rdEn_q) rdata_d = bus.ram_rdata;
        ack0_d = ~grant_q;
        ack1_d = grant_q;
        err0_d = ~grant_q & err_flag_q;
        err1_d = grant_q & err_flag_q;
      end
      RELEASE: begin
        state_d      = IDLE;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        last_grant_d = grant_q;
        busy_d       = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata_q      <= '0;
      ram_addr_q   <= '0;
      ram_rdEn_q   <= 1'b0;
      ram_wrEn_q   <= 1'b0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_flag_q   <= err_flag_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata_q      <= rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_rdEn_q   <= ram_rdEn_d;
      ram_wrEn_q   <= ram_wrEn_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_rdEn  = ram_rdEn_q;
  assign bus.ram_wrEn  = ram_wrEn_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign busy          = busy_q;
  assign grant         = grant_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences, and randomized
// traffic scored against a transaction-level model of arbitration order and ram contents.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DWIDTH(DW), .CPUAWIDTH(AW), .AWIDTH(RW)) bus ();
  mem_arbiter_if #(.DWIDTH(DW), .CPUAWIDTH(AW), .AWIDTH(RW)) busf ();

  logic       busy, grant, busy_f, grant_f;
  logic [1:0] dbg_state, dbg_state_f;

  mem_arbiter #(.DWIDTH(DW), .CPUAWIDTH(AW), .AWIDTH(RW), .FAIR(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );
  mem_arbiter #(.DWIDTH(DW), .CPUAWIDTH(AW), .AWIDTH(RW), .FAIR(0)) dut_f (
    .clk(clk), .reset(reset), .bus(busf), .busy(busy_f), .grant(grant_f), .dbg_state(dbg_state_f)
  );

  // ram model: write on the clock, read data presented while rdEn is high
  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.ram_wrEn) mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata  = bus.ram_rdEn ? mem[bus.ram_addr] : 32'h0;
  assign busf.ram_rdata = busf.ram_rdEn ? {20'h0, busf.ram_addr} : 32'h0;

  int   en_cnt = 0;
  logic both_ack = 1'b0;
  logic both_en = 1'b0;
  always @(posedge clk) if (bus.ram_rdEn || bus.ram_wrEn) en_cnt <= en_cnt + 1;
  always @(negedge clk) begin
    if ((bus.ack0 && bus.ack1) || (busf.ack0 && busf.ack1)) both_ack <= 1'b1;
    if ((bus.ram_rdEn && bus.ram_wrEn) || (busf.ram_rdEn && busf.ram_wrEn)) both_en <= 1'b1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic idle_ports();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    busf.req0 = 0; busf.we0 = 0; busf.addr0 = '0; busf.wdata0 = '0;
    busf.req1 = 0; busf.we1 = 0; busf.addr1 = '0; busf.wdata1 = '0;
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (port) begin
      bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port) bus.req1 = 0;
    else bus.req0 = 0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_en = 1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [11:0] exp_waddr;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  logic [37:0] exp_q[$];
  logic [31:0] ref_mem[16];
  logic        last_served;
  logic [31:0] last_rdata;
  logic [1:0]  mask;
  logic        r_we[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_data[2];
  logic        p, first, bad_a, seen;
  logic [37:0] e;
  int          n_acks, last_c, en_before, c0, c1, sel;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         1'b0, 12'd5,     32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678,  1'b0, 12'd8,     32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 12'd8,     32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 12'd0,     32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_4000, 32'h0,         1'b1, 12'd0,     32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_3FFC, 32'hA5A50001,  1'b0, 12'hFFF,   32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 12'hFFF,   32'hA5A50001};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0022, 32'h55555555,  1'b1, 12'd0,     32'hA5A50001};
    vecs[8] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 12'd0,     32'hA5A50001};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 12'd0,     32'h0BADF00D};

    idle_ports();
    reset = 1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset grant", 64'(grant), 64'(0));
    chk("reset acks", 64'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 64'(0));
    chk("reset enables", 64'({bus.ram_rdEn, bus.ram_wrEn}), 64'(0));
    chk("reset rdata", 64'(bus.rdata), 64'(0));
    chk("reset ram_addr", 64'(bus.ram_addr), 64'(0));
    chk("reset ram_wdata", 64'(bus.ram_wdata), 64'(0));
    reset = 0;
    preload(12'd5, 32'hDEADBEEF);
    preload(12'd0, 32'h0BADF00D);

    // directed vector table, one transaction at a time
    for (int i = 0; i < 10; i++) begin
      en_before = en_cnt;
      drive_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d rdEn", i), 64'(bus.ram_rdEn), 64'(!vecs[i].exp_err && !vecs[i].we));
      chk($sformatf("vec%0d wrEn", i), 64'(bus.ram_wrEn), 64'(!vecs[i].exp_err && vecs[i].we));
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].port));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(1));
      if (!vecs[i].exp_err) chk($sformatf("vec%0d ram_addr", i), 64'(bus.ram_addr), 64'(vecs[i].exp_waddr));
      if (!vecs[i].exp_err && vecs[i].we)
        chk($sformatf("vec%0d ram_wdata", i), 64'(bus.ram_wdata), 64'(vecs[i].wdata));
      @(negedge clk);
      chk($sformatf("vec%0d ack", i), 64'(vecs[i].port ? bus.ack1 : bus.ack0), 64'(1));
      chk($sformatf("vec%0d other ack", i), 64'(vecs[i].port ? bus.ack0 : bus.ack1), 64'(0));
      chk($sformatf("vec%0d err", i), 64'(vecs[i].port ? bus.err1 : bus.err0), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d rdata", i), 64'(bus.rdata), 64'(vecs[i].exp_rdata));
      drop_req(vecs[i].port);
      @(negedge clk);
      chk($sformatf("vec%0d ack one cycle", i), 64'({bus.ack0, bus.ack1}), 64'(0));
      chk($sformatf("vec%0d idle busy", i), 64'(busy), 64'(0));
      if (vecs[i].exp_err) chk($sformatf("vec%0d ram untouched", i), 64'(en_cnt), 64'(en_before));
    end

    // round-robin contention with both requests held from reset
    reset = 1;
    drive_req(1'b0, 1'b0, 32'h14, 32'h0);
    drive_req(1'b1, 1'b0, 32'h20, 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    n_acks = 0;
    last_c = 0;
    for (int c = 1; c <= 20 && n_acks < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        p = bus.ack1;
        chk($sformatf("fair ack%0d port", n_acks), 64'(p), 64'(n_acks % 2));
        chk($sformatf("fair ack%0d rdata", n_acks), 64'(bus.rdata), 64'(p ? 32'h12345678 : 32'hDEADBEEF));
        if (n_acks == 0) chk("fair first latency", 64'(c), 64'(2));
        else chk($sformatf("fair ack%0d spacing", n_acks), 64'(c - last_c), 64'(3));
        last_c = c;
        n_acks++;
        if (n_acks == 4) begin
          drop_req(1'b0);
          drop_req(1'b1);
        end
      end
    end
    chk("fair ack count", 64'(n_acks), 64'(4));
    drop_req(1'b0);
    drop_req(1'b1);
    repeat (2) @(negedge clk);

    // reset during the ACCESS cycle of a read
    drive_req(1'b0, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    chk("rstmid rdEn before", 64'(bus.ram_rdEn), 64'(1));
    reset = 1;
    drop_req(1'b0);
    @(negedge clk);
    chk("rstmid enables", 64'({bus.ram_rdEn, bus.ram_wrEn}), 64'(0));
    chk("rstmid acks", 64'({bus.ack0, bus.ack1}), 64'(0));
    chk("rstmid busy", 64'(busy), 64'(0));
    reset = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack0) seen = 1;
    end
    chk("rstmid no ack", 64'(seen), 64'(0));
    drive_req(1'b0, 1'b0, 32'h14, 32'h0);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack0) begin
        seen = 1;
        chk("rstmid new read rdata", 64'(bus.rdata), 64'(32'hDEADBEEF));
        chk("rstmid new read err", 64'(bus.err0), 64'(0));
      end
    end
    chk("rstmid new read acked", 64'(seen), 64'(1));
    drop_req(1'b0);
    repeat (2) @(negedge clk);

    // fixed priority: port 1 starves until port 0 lets go
    busf.req0 = 1; busf.we0 = 0; busf.addr0 = 32'h10;
    busf.req1 = 1; busf.we1 = 0; busf.addr1 = 32'h24;
    c0 = 0;
    c1 = 0;
    repeat (12) begin
      @(negedge clk);
      if (busf.ack0) c0++;
      if (busf.ack1) c1++;
    end
    chk("prio ack0 count", 64'(c0), 64'(4));
    chk("prio ack1 count", 64'(c1), 64'(0));
    busf.req0 = 0;
    seen = 0;
    c0 = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (busf.ack0) c0++;
      if (busf.ack1) begin
        seen = 1;
        chk("prio port1 rdata", 64'(busf.rdata), 64'(32'h9));
      end
    end
    chk("prio port1 served", 64'(seen), 64'(1));
    chk("prio no late ack0", 64'(c0), 64'(0));
    busf.req1 = 0;
    repeat (2) @(negedge clk);

    // randomized traffic against the transaction-level model
    do_reset();
    last_served = 1'b1;
    last_rdata  = 32'h0;
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom;
      preload(12'(w), ref_mem[w]);
    end
    for (int r = 0; r < 60; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int q = 0; q < 2; q++) begin
        r_we[q]   = 1'($urandom_range(0, 1));
        r_data[q] = $urandom;
        sel = int'($urandom_range(0, 9));
        case (sel)
          0: r_addr[q] = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
          1: r_addr[q] = ($urandom | 32'h8000_0000) & ~32'h3;
          2: r_addr[q] = 32'h4000 + (32'($urandom_range(0, 255)) << 2);
          default: r_addr[q] = 32'($urandom_range(0, 15)) << 2;
        endcase
      end
      first = (mask == 2'b11) ? ~last_served : mask[1];
      for (int i = 0; i < 2; i++) begin
        if (i == 0 || mask == 2'b11) begin
          p = (i == 0) ? first : ~first;
          bad_a = (r_addr[p][1:0] != 2'b00) || (r_addr[p] >= 32'h4000);
          if (!bad_a && r_we[p]) ref_mem[r_addr[p][5:2]] = r_data[p];
          else if (!bad_a) last_rdata = ref_mem[r_addr[p][5:2]];
          exp_q.push_back({p, bad_a, 4'(2 + 3 * i), last_rdata});
          last_served = p;
        end
      end
      for (int q = 0; q < 2; q++)
        if (mask[q]) drive_req(1'(q), r_we[q], r_addr[q], r_data[q]);
      for (int c = 1; c <= 12 && exp_q.size() > 0; c++) begin
        @(negedge clk);
        if (bus.ack0 || bus.ack1) begin
          p = bus.ack1;
          e = exp_q.pop_front();
          chk($sformatf("rnd%0d port", r), 64'(p), 64'(e[37]));
          chk($sformatf("rnd%0d err", r), 64'(p ? bus.err1 : bus.err0), 64'(e[36]));
          chk($sformatf("rnd%0d cycle", r), 64'(c), 64'(e[35:32]));
          chk($sformatf("rnd%0d rdata", r), 64'(bus.rdata), 64'(e[31:0]));
          drop_req(p);
        end
      end
      if (exp_q.size() != 0) begin
        chk($sformatf("rnd%0d pending acks", r), 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        drop_req(1'b0);
        drop_req(1'b1);
      end
      @(negedge clk);
    end

    chk("never two acks at once", 64'(both_ack), 64'(0));
    chk("never rdEn with wrEn", 64'(both_en), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-port ram between requesters. Port 0 is the CPU load/store/fetch path; port 1 is the display/string-fetch engine. It serialises accesses, drives the ram's rdEn/wrEn/word-address, returns read data, and flags misaligned or out-of-range addresses without touching the ram. The top level ties ram_wdata and ram_rdata onto the ram's tri-state data bus, enabling the driver only when ram_wrEn=1 and ram_rdEn=0.

Parameters:
DWIDTH, 32, data word width.
CPUAWIDTH, 32, requester byte-address width.
AWIDTH, 12, ram word-address width; ram holds 2^AWIDTH words.
FAIR, 1, 1 = round-robin between ports; 0 = fixed priority to port 0.

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  synchronous, active-high.
req0  in  1  port 0 request; held high with addr0/we0/wdata0 stable until ack0.
we0  in  1  port 0: 1 = write, 0 = read.
addr0  in  CPUAWIDTH  port 0 byte address.
wdata0  in  DWIDTH  port 0 write data.
ack0  out  1  port 0 one-cycle completion pulse.
err0  out  1  port 0 error; valid only while ack0=1.
req1, we1, addr1, wdata1, ack1, err1: same meanings, for port 1.
rdata  out  DWIDTH  read data for the completing port; valid while ackN=1.
ram_addr  out  AWIDTH  ram word address, equal to addr[AWIDTH+1:2].
ram_rdEn  out  1  ram read enable.
ram_wrEn  out  1  ram write enable.
ram_wdata  out  DWIDTH  write data for the bus driver.
ram_rdata  in  DWIDTH  ram data bus as read back.
busy  out  1  high in any state other than IDLE.
grant  out  1  index of the port being served; holds last value when idle.

Behaviour:
- Reset (synchronous): state=IDLE. ram_rdEn, ram_wrEn, ack0, ack1, err0, err1 and busy are 0; ram_addr, ram_wdata and rdata are 0. grant=0. last_grant=1, so port 0 wins the first contention.
- All outputs are registered.
- States:
  - IDLE -> ACCESS when any req is sampled.
  - ACCESS -> RELEASE.
  - RELEASE -> IDLE.
- IDLE, any req high:
  - Select the winner.
    - FAIR=1, both requesting: winner = ~last_grant.
    - FAIR=0, both requesting: winner = 0.
    - One requesting: that port wins.
  - Latch the winner into grant.
  - Check the winner's address. It is bad if addr[1:0]!=0, or if addr >= 4*2^AWIDTH, compared as an unsigned CPUAWIDTH-bit value.
  - Good address: ram_addr<=addr[AWIDTH+1:2], ram_wdata<=wdata, ram_wrEn<=we, ram_rdEn<=~we.
  - Bad address: both enables stay 0 and an internal error flag is set.
  - busy<=1.
- ACCESS:
  - ram_rdEn<=0 and ram_wrEn<=0.
  - Good read: rdata<=ram_rdata, captured one cycle after rdEn rose (ram read latency is one clock).
  - Write or bad address: rdata holds its previous value.
  - ack[grant]<=1; err[grant]<=error flag.
- RELEASE:
  - ack and err <=0; last_grant<=grant; busy<=0.
  - This cycle lets the requester drop req.
- Timing: req sampled at edge k -> enables high in cycle k+1 -> ack visible in cycle k+2 only.
  - Peak rate is one access per 3 cycles.
  - Continuous alternating requests are served 0,1,0,1.
- Requester rules:
  - A requester must drop req, or present a new request, no later than the RELEASE cycle. A req still high in IDLE is treated as a new request.
  - A req dropped before ack does not abort the access: the access completes and ack still pulses.
  - Changing addr/we/wdata after IDLE has no effect; they are latched.
- Reset mid-operation (ACCESS or RELEASE): enables and acks drop on the next edge. No ack is issued for the aborted access. An in-flight write may have been committed to the ram.
- ack0 and ack1 are never high in the same cycle. ram_rdEn and ram_wrEn are never high together.

Test Plan:
- Port 0 read: write 0xDEADBEEF at word 5 by preload, then req0 with addr0=0x14, we0=0 -> ram_rdEn=1 and ram_addr=5 one cycle later; ack0=1 with rdata=0xDEADBEEF and err0=0 two cycles after the request is sampled; ack0 lasts exactly one cycle.
- Write-readback via port 1: req1 with addr1=0x20, we1=1, wdata1=0x12345678, then a read of 0x20 -> ram_wrEn pulses one cycle at ram_addr=8; the read returns 0x12345678 on rdata with ack1.
- Contention with FAIR=1: req0 and req1 held high continuously from reset -> acks arrive in the order 0,1,0,1, spaced 3 cycles apart, and are never simultaneous.
- Contention with FAIR=0: both held high -> only ack0 pulses; port 1 is served only after req0 drops.
- Error paths: addr0=0x3 -> ack0=1 and err0=1 with no rdEn/wrEn pulse and rdata unchanged; addr0=0x4000 (AWIDTH=12) -> err0=1, ram untouched.
- Reset mid-ACCESS: assert reset in the ACCESS cycle of a read -> the next cycle has all enables, acks and busy at 0; no ack0 is issued; a new req0 afterwards completes normally.
